// File: rtl/bip_pkg.sv
// Shared definitions for the BIP I execute stage: field widths, opcodes
// and the operand sign-extension helper.
package bip_pkg;

  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 11;
  localparam int DATA_W    = 16;

  typedef enum logic [OPCODE_W-1:0] {
    OP_HLT  = 5'd0,
    OP_STO  = 5'd1,
    OP_LD   = 5'd2,
    OP_LDI  = 5'd3,
    OP_ADD  = 5'd4,
    OP_ADDI = 5'd5,
    OP_SUB  = 5'd6,
    OP_SUBI = 5'd7
  } opcode_e;

  function automatic logic [DATA_W-1:0] sign_ext(input logic [OPERAND_W-1:0] v);
    return {{(DATA_W-OPERAND_W){v[OPERAND_W-1]}}, v};
  endfunction

endpackage

// File: rtl/bip_data_ram.sv
// Data RAM for the BIP I: asynchronous read, synchronous write.
// The array has no reset, so contents survive a processor reset.
module bip_data_ram
  import bip_pkg::*;
#(
  parameter int AW    = 11,
  parameter int DEPTH = 2048
) (
  input  logic              Clk,
  input  logic              We,
  input  logic [AW-1:0]     WAddr,
  input  logic [DATA_W-1:0] WData,
  input  logic [AW-1:0]     RAddr,
  output logic [DATA_W-1:0] RData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (We) begin
      mem[WAddr] <= WData;
    end
  end

  assign RData = mem[RAddr];

endmodule

// File: rtl/bip_exec.sv
// BIP I execute stage: pairs the registered ROM word with its PC address,
// decodes it and updates the accumulator, data RAM, flags and retire count.
module bip_exec
  import bip_pkg::*;
#(
  parameter int DATA_AW    = 11,
  parameter int DATA_DEPTH = 2048
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [OPERAND_W-1:0] Addr,
  input  logic [DATA_W-1:0]    InstrData,
  output logic [DATA_W-1:0]    Acc,
  output logic [OPERAND_W-1:0] ExecPc,
  output logic                 Halted,
  output logic                 Illegal,
  output logic [DATA_W-1:0]    Retired
);

  logic                 FetchValid;
  logic [OPERAND_W-1:0] AddrD;

  logic                 exec_en;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand;
  logic [DATA_W-1:0]    imm;
  logic [DATA_AW-1:0]   ram_addr;
  logic [DATA_W-1:0]    ram_rdata;
  logic [DATA_W-1:0]    acc_next;
  logic                 ram_we;
  logic                 hlt_hit;
  logic                 illegal_hit;

  assign opcode   = InstrData[DATA_W-1 -: OPCODE_W];
  assign operand  = InstrData[OPERAND_W-1:0];
  assign imm      = sign_ext(operand);
  assign ram_addr = operand[DATA_AW-1:0];

  // Reset in the same cycle suppresses execution, which also drops a pending STO.
  assign exec_en = FetchValid & ~Halted & ~Reset;

  bip_data_ram #(
    .AW    (DATA_AW),
    .DEPTH (DATA_DEPTH)
  ) u_ram (
    .Clk   (Clk),
    .We    (ram_we),
    .WAddr (ram_addr),
    .WData (Acc),
    .RAddr (ram_addr),
    .RData (ram_rdata)
  );

  always_comb begin
    acc_next    = Acc;
    ram_we      = 1'b0;
    hlt_hit     = 1'b0;
    illegal_hit = 1'b0;
    case (opcode)
      OP_HLT:  hlt_hit  = 1'b1;
      OP_STO:  ram_we   = exec_en;
      OP_LD:   acc_next = ram_rdata;
      OP_LDI:  acc_next = imm;
      OP_ADD:  acc_next = Acc + ram_rdata;
      OP_ADDI: acc_next = Acc + imm;
      OP_SUB:  acc_next = Acc - ram_rdata;
      OP_SUBI: acc_next = Acc - imm;
      default: illegal_hit = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      FetchValid <= 1'b0;
      AddrD      <= '0;
      Acc        <= '0;
      ExecPc     <= '0;
      Halted     <= 1'b0;
      Illegal    <= 1'b0;
      Retired    <= '0;
    end else begin
      FetchValid <= 1'b1;
      AddrD      <= Addr;
      if (exec_en) begin
        ExecPc <= AddrD;
        Acc    <= acc_next;
        if (Retired != {DATA_W{1'b1}}) begin
          Retired <= Retired + 16'd1;
        end
        if (hlt_hit) begin
          Halted <= 1'b1;
        end
        if (illegal_hit) begin
          Illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bip_exec.sv
// Scoreboard bench for bip_exec: each test queues a hand-computed per-cycle
// trace, and a monitor pops one entry after every rising edge and compares.
module tb_bip_exec;
  import bip_pkg::*;

  typedef struct {
    logic [15:0] acc;
    logic [10:0] pc;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;
    bit          chk;
    string       name;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] Addr = '0;
  logic [15:0] InstrData = '0;
  logic [15:0] Acc;
  logic [10:0] ExecPc;
  logic        Halted;
  logic        Illegal;
  logic [15:0] Retired;

  logic [15:0] rom [2048];
  exp_t        expQ [$];
  int          checks = 0;
  int          errors = 0;

  bip_exec dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Addr      (Addr),
    .InstrData (InstrData),
    .Acc       (Acc),
    .ExecPc    (ExecPc),
    .Halted    (Halted),
    .Illegal   (Illegal),
    .Retired   (Retired)
  );

  always #5 Clk = ~Clk;

  // Upstream PC and registered program ROM.
  always @(posedge Clk) begin
    Addr      <= Reset ? 11'd0 : Addr + 11'd1;
    InstrData <= rom[Addr];
  end

  task automatic checkOutput(input exp_t e);
    checks++;
    if (Acc !== e.acc || ExecPc !== e.pc || Halted !== e.halted ||
        Illegal !== e.illegal || Retired !== e.retired) begin
      errors++;
      $display("[TB] FAIL %s: got acc=%h pc=%0d halted=%b illegal=%b retired=%h, want acc=%h pc=%0d halted=%b illegal=%b retired=%h",
               e.name, Acc, ExecPc, Halted, Illegal, Retired,
               e.acc, e.pc, e.halted, e.illegal, e.retired);
    end
  endtask

  always @(posedge Clk) begin
    #1;
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      if (e.chk) checkOutput(e);
    end
  end

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] opd);
    return {op, opd};
  endfunction

  function automatic void pushExp(input string name, input logic [15:0] acc,
                                  input logic [10:0] pc, input logic halted,
                                  input logic illegal, input logic [15:0] retired,
                                  input bit chk);
    exp_t e;
    e.name = name; e.acc = acc; e.pc = pc; e.halted = halted;
    e.illegal = illegal; e.retired = retired; e.chk = chk;
    expQ.push_back(e);
  endfunction

  task automatic fillRom(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) rom[i] = w;
  endtask

  task automatic applyStimulus(input logic rst, input int cycles);
    Reset = rst;
    repeat (cycles) @(negedge Clk);
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = expQ.size() + 20;
    while (expQ.size() > 0 && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s drain: %0d expectations left, want 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  // Reset edge and first fetch edge both show reset values.
  task automatic pushResetPair(input string name);
    pushExp({name, "_e0"}, 16'd0, 11'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    pushExp({name, "_e1"}, 16'd0, 11'd0, 1'b0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic testResetSeq();
    logic [15:0] accs [3];
    accs = '{16'd5, 16'd8, 16'd8};
    fillRom(enc(OP_HLT, 11'd0));
    rom[0] = enc(OP_LDI, 11'd5);
    rom[1] = enc(OP_ADDI, 11'd3);
    rom[2] = enc(OP_HLT, 11'd0);
    pushResetPair("seq");
    for (int k = 0; k < 3; k++)
      pushExp("seq_run", accs[k], 11'(k), k == 2, 1'b0, 16'(k + 1), 1'b1);
    for (int k = 0; k < 10; k++)
      pushExp("seq_hold", 16'd8, 11'd2, 1'b1, 1'b0, 16'd3, 1'b1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 0);
    waitDrain("seq");
  endtask

  task automatic testMemory();
    logic [15:0] accs [10];
    accs = '{16'd100, 16'd100, 16'd0, 16'd100, 16'd200,
             16'd100, 16'd123, 16'd123, 16'd123, 16'd123};
    fillRom(enc(OP_HLT, 11'd0));
    rom[0] = enc(OP_LDI, 11'd100);
    rom[1] = enc(OP_STO, 11'd7);
    rom[2] = enc(OP_LDI, 11'd0);
    rom[3] = enc(OP_LD, 11'd7);
    rom[4] = enc(OP_ADD, 11'd7);
    rom[5] = enc(OP_SUB, 11'd7);
    rom[6] = enc(OP_ADDI, 11'd23);
    rom[7] = enc(OP_STO, 11'd7);
    rom[8] = enc(OP_LD, 11'd7);
    rom[9] = enc(OP_HLT, 11'd0);
    pushResetPair("mem");
    for (int k = 0; k < 10; k++)
      pushExp("mem_run", accs[k], 11'(k), k == 9, 1'b0, 16'(k + 1), 1'b1);
    for (int k = 0; k < 2; k++)
      pushExp("mem_hold", 16'd123, 11'd9, 1'b1, 1'b0, 16'd10, 1'b1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 0);
    waitDrain("mem");
  endtask

  task automatic testSignIllegal();
    logic [15:0] accs [7];
    accs = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'd42, 16'd42, 16'd43, 16'd43};
    fillRom(enc(OP_HLT, 11'd0));
    rom[0] = enc(OP_LDI, 11'h7FF);
    rom[1] = enc(OP_ADDI, 11'd1);
    rom[2] = enc(OP_SUBI, 11'd1);
    rom[3] = enc(OP_LDI, 11'd42);
    rom[4] = enc(5'h1F, 11'd0);
    rom[5] = enc(OP_ADDI, 11'd1);
    rom[6] = enc(OP_HLT, 11'd0);
    pushResetPair("sgn");
    for (int k = 0; k < 7; k++)
      pushExp("sgn_run", accs[k], 11'(k), k == 6, k >= 4, 16'(k + 1), 1'b1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 0);
    waitDrain("sgn");
  endtask

  // Reset lands on the STO 9 edge; the follow-up program reads RAM[9] back.
  task automatic testMidReset();
    fillRom(enc(OP_HLT, 11'd0));
    rom[0] = enc(OP_LDI, 11'd3);
    rom[1] = enc(OP_STO, 11'd9);
    rom[2] = enc(OP_LDI, 11'd5);
    rom[3] = enc(OP_STO, 11'd9);
    pushResetPair("mid");
    pushExp("mid_run", 16'd3, 11'd0, 1'b0, 1'b0, 16'd1, 1'b1);
    pushExp("mid_run", 16'd3, 11'd1, 1'b0, 1'b0, 16'd2, 1'b1);
    pushExp("mid_run", 16'd5, 11'd2, 1'b0, 1'b0, 16'd3, 1'b1);
    pushResetPair("mid_rst");
    pushExp("mid_ld9", 16'd3, 11'd0, 1'b0, 1'b0, 16'd1, 1'b1);
    pushExp("mid_hlt", 16'd3, 11'd1, 1'b1, 1'b0, 16'd2, 1'b1);
    pushExp("mid_hold", 16'd3, 11'd1, 1'b1, 1'b0, 16'd2, 1'b1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 4);
    fillRom(enc(OP_HLT, 11'd0));
    rom[0] = enc(OP_LD, 11'd9);
    rom[1] = enc(OP_HLT, 11'd0);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 0);
    waitDrain("mid");
  endtask

  task automatic testSaturation();
    bit chk;
    fillRom(enc(OP_ADDI, 11'd0));
    pushResetPair("sat");
    for (int k = 0; k < 65540; k++) begin
      chk = (k == 0) || (k >= 2046 && k <= 2049) || (k >= 65533 && k <= 65536) || (k == 65539);
      pushExp("sat_run", 16'd0, 11'(k % 2048), 1'b0, 1'b0,
              (k + 1 > 65535) ? 16'hFFFF : 16'(k + 1), chk);
    end
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 0);
    waitDrain("sat");
  endtask

  initial begin
    $display("[TB] bip_exec scoreboard bench starting");
    fillRom(enc(OP_HLT, 11'd0));
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    testResetSeq();
    testMemory();
    testSignIllegal();
    testMidReset();
    testSaturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
